// File: rtl/rng_sample_sched_if.sv
// Port bundle for the TRNG sample scheduler: control, config, entropy pin and word output handshake.
// The master side drives control/config and consumes words; the slave side is the scheduler.
interface rng_sample_sched_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] sample_div;
    logic [1:0]       src_sel_cfg;
    logic             auto_rotate;
    logic             rnd_src;
    logic             rnd_src_en;
    logic [1:0]       rnd_src_sel;
    logic [31:0]      ehr_data;
    logic             ehr_valid;
    logic             ehr_ready;
    logic             busy;
    logic             err_rep;

    modport master (
        output start, stop, sample_div, src_sel_cfg, auto_rotate, rnd_src, ehr_ready,
        input  rnd_src_en, rnd_src_sel, ehr_data, ehr_valid, busy, err_rep
    );

    modport slave (
        input  start, stop, sample_div, src_sel_cfg, auto_rotate, rnd_src, ehr_ready,
        output rnd_src_en, rnd_src_sel, ehr_data, ehr_valid, busy, err_rep
    );
endinterface

// File: rtl/rng_sample_sched.sv
// TRNG source sequencer: warm-up, decimated sampling, 32-bit packing and repetition-count health test.
// Optional Von Neumann debiaser between health test and packer when RNG_SCHED_VN_EN is defined.
//
// state  | meaning
// IDLE   | source off, waiting for start
// WARMUP | source on, waiting out oscillator settling time
// SAMPLE | taking one synchronised bit every N cycles into the packer
// HOLD   | full word presented on ehr_*, sampling paused
// ERROR  | health test failed, source off until stop
module rng_sample_sched #(
    parameter int WARMUP_CYC = 256,
    parameter int RC_LIMIT   = 32,
    parameter int CNT_W      = 16
) (
    input logic              rng_clk,
    input logic              rst,
    rng_sample_sched_if.slave bus
);
    localparam int WU_W = (WARMUP_CYC > 2) ? $clog2(WARMUP_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t           r_state;
    logic [WU_W-1:0]  r_wu_cnt;
    logic [CNT_W-1:0] r_dec_cnt;
    logic [CNT_W-1:0] r_div_m1;
    logic             r_rotate;
    logic [1:0]       r_sel;
    logic             r_en;
    logic [31:0]      r_data;
    logic             r_valid;
    logic [4:0]       r_bitcnt;
    logic [7:0]       r_run;
    logic             r_prev;
    logic             r_err;
    logic             r_sync1;
    logic             r_sync2;

    logic             w_take;
    logic [7:0]       w_run_next;
    logic             w_health_fail;
    logic             w_push;
    logic             w_bit;
    logic             w_word_done;
    logic             w_xfer;

    assign w_take = (r_state == ST_SAMPLE) && (r_dec_cnt == '0);
    assign w_xfer = r_valid && bus.ehr_ready;

    // A zero run count marks the first sample after warm-up: it always starts a fresh run.
    always_comb begin
        w_run_next = 8'd1;
        if ((r_run != 8'd0) && (r_sync2 == r_prev)) begin
            w_run_next = (r_run == 8'hFF) ? r_run : r_run + 8'd1;
        end
    end

    assign w_health_fail = w_take && (w_run_next == 8'(RC_LIMIT));

`ifdef RNG_SCHED_VN_EN
    logic r_vn_have;
    logic r_vn_first;

    assign w_push = w_take && r_vn_have && (r_vn_first != r_sync2);
    assign w_bit  = r_vn_first;
`else
    assign w_push = w_take;
    assign w_bit  = r_sync2;
`endif

    assign w_word_done = w_push && (r_bitcnt == 5'd31);

    always_ff @(posedge rng_clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_wu_cnt  <= '0;
            r_dec_cnt <= '0;
            r_div_m1  <= '0;
            r_rotate  <= 1'b0;
            r_sel     <= 2'd0;
            r_en      <= 1'b0;
            r_data    <= 32'd0;
            r_valid   <= 1'b0;
            r_bitcnt  <= 5'd0;
            r_run     <= 8'd0;
            r_prev    <= 1'b0;
            r_err     <= 1'b0;
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
`ifdef RNG_SCHED_VN_EN
            r_vn_have  <= 1'b0;
            r_vn_first <= 1'b0;
`endif
        end else begin
            r_sync1 <= bus.rnd_src;
            r_sync2 <= r_sync1;
            if (bus.stop) begin
                r_state  <= ST_IDLE;
                r_en     <= 1'b0;
                r_valid  <= 1'b0;
                r_bitcnt <= 5'd0;
                r_data   <= 32'd0;
`ifdef RNG_SCHED_VN_EN
                r_vn_have <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            r_state  <= ST_WARMUP;
                            r_div_m1 <= (bus.sample_div == '0) ? '0 : bus.sample_div - 1'b1;
                            r_rotate <= bus.auto_rotate;
                            r_sel    <= bus.src_sel_cfg;
                            r_en     <= 1'b1;
                            r_err    <= 1'b0;
                            r_wu_cnt <= WU_W'(WARMUP_CYC - 1);
                            r_run    <= 8'd0;
                            r_bitcnt <= 5'd0;
                            r_data   <= 32'd0;
`ifdef RNG_SCHED_VN_EN
                            r_vn_have <= 1'b0;
`endif
                        end
                    end
                    ST_WARMUP: begin
                        if (r_wu_cnt == '0) begin
                            r_state   <= ST_SAMPLE;
                            r_dec_cnt <= r_div_m1;
                        end else begin
                            r_wu_cnt <= r_wu_cnt - 1'b1;
                        end
                    end
                    ST_SAMPLE: begin
                        if (r_dec_cnt == '0) begin
                            r_dec_cnt <= r_div_m1;
                            r_prev    <= r_sync2;
                            r_run     <= w_run_next;
                            // A failing sample never completes a word, even if it is the 32nd bit.
                            if (w_health_fail) begin
                                r_state  <= ST_ERROR;
                                r_en     <= 1'b0;
                                r_err    <= 1'b1;
                                r_valid  <= 1'b0;
                                r_data   <= 32'd0;
                                r_bitcnt <= 5'd0;
`ifdef RNG_SCHED_VN_EN
                                r_vn_have <= 1'b0;
`endif
                            end else begin
`ifdef RNG_SCHED_VN_EN
                                r_vn_have <= ~r_vn_have;
                                if (!r_vn_have) begin
                                    r_vn_first <= r_sync2;
                                end
`endif
                                if (w_push) begin
                                    r_data   <= {r_data[30:0], w_bit};
                                    r_bitcnt <= r_bitcnt + 5'd1;
                                end
                                if (w_word_done) begin
                                    r_state <= ST_HOLD;
                                    r_valid <= 1'b1;
                                end
                            end
                        end else begin
                            r_dec_cnt <= r_dec_cnt - 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (w_xfer) begin
                            r_valid <= 1'b0;
                            if (r_rotate) begin
                                r_sel    <= r_sel + 2'd1;
                                r_state  <= ST_WARMUP;
                                r_wu_cnt <= WU_W'(WARMUP_CYC - 1);
                                r_run    <= 8'd0;
`ifdef RNG_SCHED_VN_EN
                                r_vn_have <= 1'b0;
`endif
                            end else begin
                                r_state   <= ST_SAMPLE;
                                r_dec_cnt <= r_div_m1;
                            end
                        end
                    end
                    ST_ERROR: begin
                        r_state <= ST_ERROR;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_en    <= 1'b0;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rnd_src_en  = r_en;
    assign bus.rnd_src_sel = r_sel;
    assign bus.ehr_data    = r_data;
    assign bus.ehr_valid   = r_valid;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.err_rep     = r_err;
endmodule
